// File: rtl/photon_ipi_histogrammer.sv
// Per-channel photon counters plus an inter-photon-interval histogram with addressed readout.
// Latency: hits land 1 cycle after buffer, reads return 1 cycle after rd_en; no backpressure, one read per cycle.
module photon_ipi_histogrammer #(
  parameter int NCHAN     = 8,
  parameter int CNT_W     = 32,
  parameter int NBINS     = 64,
  parameter int BIN_SHIFT = 0,
  parameter int CC_W      = 16,
  parameter int ADDR_W    = 8
) (
  input  logic              clkin,
  input  logic              reset,
  input  logic [NCHAN-1:0]  buffer,
  input  logic [NCHAN-1:0]  chan_mask,
  input  logic              enable,
  input  logic              clear,
  output logic              clear_busy,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [CNT_W-1:0]  rd_data,
  output logic              rd_valid
);

  localparam int SW = (NBINS > 1) ? $clog2(NBINS) : 1;

  logic [NCHAN-1:0] buf_q;
  logic [CNT_W-1:0] ipi   [NBINS];
  logic [CNT_W-1:0] chcnt [NCHAN];
  logic [CNT_W-1:0] ovf;
  logic [CNT_W-1:0] total;
  logic [CC_W-1:0]  cyc;
  logic             armed;
  logic [SW-1:0]    sweep_idx;
  logic             hit;
  logic             acc;
  logic             bin_en;
  logic [31:0]      bin;
  logic [31:0]      addr32;
  logic [CNT_W-1:0] rd_mux;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign hit    = |(buf_q & chan_mask);
  assign acc    = enable && !clear_busy;
  assign bin    = 32'(cyc >> BIN_SHIFT);
  assign bin_en = acc && hit && armed;
  assign addr32 = 32'(rd_addr);

  // Input register, interval counter, arming and sweep sequencing.
  always_ff @(posedge clkin) begin
    if (reset) begin
      buf_q      <= '0;
      cyc        <= '0;
      armed      <= 1'b0;
      clear_busy <= 1'b0;
      sweep_idx  <= '0;
    end else begin
      buf_q <= buffer;
      if (clear_busy) begin
        cyc   <= '0;
        armed <= 1'b0;
        if (sweep_idx == SW'(NBINS - 1)) begin
          clear_busy <= 1'b0;
          sweep_idx  <= '0;
        end else begin
          sweep_idx <= sweep_idx + 1'b1;
        end
      end else begin
        if (clear) begin
          clear_busy <= 1'b1;
          sweep_idx  <= '0;
        end
        if (hit) begin
          cyc   <= '0;
          armed <= 1'b1;
        end else if (!(&cyc)) begin
          cyc <= cyc + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      ovf   <= '0;
      total <= '0;
      for (int i = 0; i < NCHAN; i++) chcnt[i] <= '0;
      for (int b = 0; b < NBINS; b++) ipi[b] <= '0;
    end else begin
      // The sweep walks one bin per cycle; the bin being swept wins over a concurrent increment.
      for (int b = 0; b < NBINS; b++) begin
        if (clear_busy && (32'(sweep_idx) == 32'(b)))
          ipi[b] <= '0;
        else if (bin_en && (bin == 32'(b)))
          ipi[b] <= sat_inc(ipi[b]);
      end
      if (clear_busy && (sweep_idx == '0)) begin
        ovf   <= '0;
        total <= '0;
        for (int i = 0; i < NCHAN; i++) chcnt[i] <= '0;
      end else if (acc) begin
        for (int i = 0; i < NCHAN; i++)
          if (buf_q[i]) chcnt[i] <= sat_inc(chcnt[i]);
        if (hit) total <= sat_inc(total);
        if (bin_en && (bin >= 32'(NBINS))) ovf <= sat_inc(ovf);
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int b = 0; b < NBINS; b++)
      if (addr32 == 32'(b)) rd_mux = ipi[b];
    for (int i = 0; i < NCHAN; i++)
      if (addr32 == 32'(NBINS + i)) rd_mux = chcnt[i];
    if (addr32 == 32'(NBINS + NCHAN))     rd_mux = ovf;
    if (addr32 == 32'(NBINS + NCHAN + 1)) rd_mux = total;
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_mux;
    end
  end

endmodule

// File: tb/tb_photon_ipi_histogrammer.sv
// Bench for photon_ipi_histogrammer: a default instance and a narrow (CNT_W=4, BIN_SHIFT=2) one share stimulus.
module tb_photon_ipi_histogrammer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        clear = 1'b0;
  logic        rd_en = 1'b0;
  logic [7:0]  buffer = '0;
  logic [7:0]  chan_mask = 8'hFF;
  logic [7:0]  rd_addr = '0;
  logic        clear_busy_a, rd_valid_a, clear_busy_b, rd_valid_b;
  logic [31:0] rd_data_a;
  logic [3:0]  rd_data_b;

  photon_ipi_histogrammer u_dut_a (
    .clkin(clk), .reset(reset), .buffer(buffer), .chan_mask(chan_mask), .enable(enable),
    .clear(clear), .clear_busy(clear_busy_a), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_a), .rd_valid(rd_valid_a));

  photon_ipi_histogrammer #(.CNT_W(4), .BIN_SHIFT(2)) u_dut_b (
    .clkin(clk), .reset(reset), .buffer(buffer), .chan_mask(chan_mask), .enable(enable),
    .clear(clear), .clear_busy(clear_busy_b), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_b), .rd_valid(rd_valid_b));

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] ea;
    logic [31:0] eb;
  } vec_t;

  vec_t        sb[$];
  vec_t        mv;
  vec_t        t1 [12];
  logic [31:0] exp_a [74];
  logic [31:0] exp_b [74];
  int          n_cmp = 0;
  int          n_err = 0;
  int          busy_a, busy_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Read scoreboard: every rd_valid pops the oldest outstanding request.
  initial forever begin
    @(posedge clk);
    #1;
    if (rd_valid_a || rd_valid_b) begin
      if (sb.size() == 0) begin
        check("unexpected_rd_valid", 32'd1, 32'd0);
      end else begin
        mv = sb.pop_front();
        check($sformatf("rd_valid_a[%0d]", mv.addr), {31'd0, rd_valid_a}, 32'd1);
        check($sformatf("rd_valid_b[%0d]", mv.addr), {31'd0, rd_valid_b}, 32'd1);
        check($sformatf("rd_data_a[%0d]", mv.addr), rd_data_a, mv.ea);
        check($sformatf("rd_data_b[%0d]", mv.addr), {28'd0, rd_data_b}, mv.eb);
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick(input logic [7:0] b);
    @(negedge clk);
    buffer = b;
    rd_en  = 1'b0;
    clear  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(8'h00);
  endtask

  task automatic hits(input logic [7:0] b, input int n, input int gap);
    for (int k = 0; k < n; k++) begin
      tick(b);
      idle(gap - 1);
    end
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] ea, input logic [31:0] eb);
    vec_t v;
    @(negedge clk);
    buffer  = 8'h00;
    clear   = 1'b0;
    rd_en   = 1'b1;
    rd_addr = a;
    v.addr = a; v.ea = ea; v.eb = eb;
    sb.push_back(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; buffer = '0; rd_en = 1'b0; clear = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic zero_exp();
    for (int i = 0; i < 74; i++) begin
      exp_a[i] = '0;
      exp_b[i] = '0;
    end
  endtask

  task automatic read_all();
    for (int i = 0; i < 74; i++) rd(8'(i), exp_a[i], exp_b[i]);
    idle(3);
  endtask

  initial begin
    t1[0]  = '{8'd0,   32'd1, 32'd2};
    t1[1]  = '{8'd1,   32'd0, 32'd0};
    t1[2]  = '{8'd2,   32'd1, 32'd0};
    t1[3]  = '{8'd3,   32'd0, 32'd0};
    t1[4]  = '{8'd63,  32'd0, 32'd0};
    t1[5]  = '{8'd64,  32'd3, 32'd3};
    t1[6]  = '{8'd65,  32'd0, 32'd0};
    t1[7]  = '{8'd71,  32'd0, 32'd0};
    t1[8]  = '{8'd72,  32'd0, 32'd0};
    t1[9]  = '{8'd73,  32'd3, 32'd3};
    t1[10] = '{8'd74,  32'd0, 32'd0};
    t1[11] = '{8'd255, 32'd0, 32'd0};

    // Reset state
    do_reset();
    @(posedge clk); #1;
    check("reset_clear_busy_a", {31'd0, clear_busy_a}, 32'd0);
    check("reset_rd_valid_a",   {31'd0, rd_valid_a},   32'd0);
    check("reset_clear_busy_b", {31'd0, clear_busy_b}, 32'd0);
    zero_exp();
    read_all();

    // Hits at cycles 10, 13, 14 on ch0
    do_reset();
    idle(10);
    tick(8'h01); idle(2); tick(8'h01); tick(8'h01);
    idle(4);
    for (int i = 0; i < 12; i++) rd(t1[i].addr, t1[i].ea, t1[i].eb);
    idle(3);

    // Five hits 9 cycles apart: cyc=8 -> bin 8 (shift 0), bin 2 (shift 2)
    do_reset();
    hits(8'h01, 5, 9);
    idle(2);
    rd(8'd2, 32'd0, 32'd4); rd(8'd8, 32'd4, 32'd0); rd(8'd64, 32'd5, 32'd5);
    rd(8'd72, 32'd0, 32'd0); rd(8'd73, 32'd5, 32'd5);
    idle(3);

    // 70-cycle spacing, then a gap that would alias to cyc=5 if the counter wrapped
    do_reset();
    hits(8'h01, 3, 70);
    idle(65542 - 70);
    tick(8'h01);
    idle(3);
    rd(8'd17, 32'd0, 32'd2); rd(8'd72, 32'd3, 32'd1); rd(8'd5, 32'd0, 32'd0);
    rd(8'd1, 32'd0, 32'd0);  rd(8'd73, 32'd4, 32'd4); rd(8'd64, 32'd4, 32'd4);
    idle(3);

    // Mask ch1 only; ch0/ch1 alternate every 3 cycles
    do_reset();
    chan_mask = 8'h02;
    for (int k = 0; k < 4; k++) begin
      tick(8'h01); idle(2); tick(8'h02); idle(2);
    end
    idle(2);
    zero_exp();
    exp_a[5] = 3; exp_a[64] = 4; exp_a[65] = 4; exp_a[73] = 4;
    exp_b[1] = 3; exp_b[64] = 4; exp_b[65] = 4; exp_b[73] = 4;
    read_all();

    // Clear sweep mid-stream, with hits and a second clear while busy
    chan_mask = 8'hFF;
    @(negedge clk);
    clear = 1'b1; buffer = 8'h00; rd_en = 1'b0;
    busy_a = 0; busy_b = 0;
    for (int i = 1; i <= 80; i++) begin
      tick(((i % 10) == 5 && i <= 55) ? 8'h01 : 8'h00);
      if (i == 30) clear = 1'b1;
      if (clear_busy_a) busy_a++;
      if (clear_busy_b) busy_b++;
    end
    check("sweep_len_a", 32'(busy_a), 32'd64);
    check("sweep_len_b", 32'(busy_b), 32'd64);
    zero_exp();
    read_all();
    tick(8'h01); idle(2); tick(8'h01);
    idle(3);
    zero_exp();
    exp_a[2] = 1; exp_a[64] = 2; exp_a[73] = 2;
    exp_b[0] = 1; exp_b[64] = 2; exp_b[73] = 2;
    read_all();

    // Saturation on the narrow instance: 20 back-to-back hits on ch3
    do_reset();
    hits(8'h08, 20, 1);
    idle(3);
    rd(8'd67, 32'd20, 32'd15); rd(8'd73, 32'd20, 32'd15);
    rd(8'd0, 32'd19, 32'd15);  rd(8'd72, 32'd0, 32'd0);
    idle(3);

    // Reset wins over a concurrent read and clear
    @(negedge clk);
    reset = 1'b1; rd_en = 1'b1; rd_addr = 8'd67; clear = 1'b1;
    @(posedge clk); #1;
    check("rst_rd_valid_a",   {31'd0, rd_valid_a},   32'd0);
    check("rst_rd_valid_b",   {31'd0, rd_valid_b},   32'd0);
    check("rst_clear_busy_a", {31'd0, clear_busy_a}, 32'd0);
    check("rst_clear_busy_b", {31'd0, clear_busy_b}, 32'd0);
    @(negedge clk);
    reset = 1'b0; rd_en = 1'b0; clear = 1'b0;
    rd(8'd67, 32'd0, 32'd0); rd(8'd73, 32'd0, 32'd0); rd(8'd0, 32'd0, 32'd0);
    idle(1);
    @(posedge clk); #2;
    check("post_rst_clear_busy_a", {31'd0, clear_busy_a}, 32'd0);

    for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/photon_ipi_histogrammer.md
Name: photon_ipi_histogrammer

Overview:
Parametrised successor to the 8-channel photon counter and inter-photon-interval (IPI) histogram. Accumulates per-channel hit counts and a histogram of the cycle spacing between successive hits on a maskable set of channels, with configurable bin width. Also keeps an overflow bin and a total-hit counter. Results are read through an addressed readout port rather than wide array outputs; clearing is a timed sweep. Sits between the input capture buffer and the readout/USB register layer.

Parameters:
NCHAN, 8, number of input channels
CNT_W, 32, width of every accumulator
NBINS, 64, number of IPI bins
BIN_SHIFT, 0, bin width = 2^BIN_SHIFT cycles
CC_W, 16, width of interval cycle counter
ADDR_W, 8, readout address width; NBINS+NCHAN+2 <= 2^ADDR_W required

Ports:
clkin  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high; clears everything
buffer  in  NCHAN  per-channel hit flags for this cycle
chan_mask  in  NCHAN  channels contributing to IPI timing
enable  in  1  accumulation enable
clear  in  1  pulse: start clear sweep
clear_busy  out  1  high while sweep in progress
rd_en  in  1  read request
rd_addr  in  ADDR_W  read address
rd_data  out  CNT_W  read result
rd_valid  out  1  rd_data valid pulse

Behaviour:
- Reset: synchronous, active-high, takes effect on the sampling edge. All bins, channel counts, overflow, total, cycle counter, armed flag, clear_busy, rd_data and rd_valid go to 0. Reset overrides clear, reads and accumulation.
- Input stage: buf_q <= buffer every cycle. hit = |(buf_q & chan_mask). All accumulation uses buf_q, giving 1 cycle of latency from buffer.
- Accumulate (enable=1, clear_busy=0):
  - chcnt[i] += buf_q[i].
  - total += 1 when hit.
  - All accumulators saturate at 2^CNT_W-1; no wrap.
- Interval counter cyc:
  - On a hit cycle, cyc <= 0.
  - Otherwise cyc <= cyc+1, saturating at 2^CC_W-1.
  - cyc runs regardless of enable; it is held at 0 during a sweep.
- IPI binning, on a hit cycle with enable=1 and armed=1:
  - bin = cyc >> BIN_SHIFT.
  - If bin < NBINS, ipi[bin] += 1; else ovf += 1.
  - Hits in consecutive cycles land in bin 0. Hits N cycles apart give cyc = N-1.
- Armed flag: cleared by reset and by a sweep; set on the first hit after either.
  - The first hit after reset or clear records no interval; it only restarts cyc.
  - Hits with enable=0 still restart cyc and set armed, but increment nothing.
- Clear sweep:
  - clear is sampled while clear_busy=0; clear_busy rises the next cycle and stays high exactly NBINS cycles.
  - Sweep cycle k zeroes ipi[k], k = 0..NBINS-1.
  - Sweep cycle 0 also zeroes chcnt[], ovf, total, cyc and armed.
  - While busy, all accumulation is suppressed and hits are ignored; clear is ignored.
  - Accumulation resumes the cycle clear_busy falls.
- Readout:
  - rd_en is sampled at edge t; rd_data and rd_valid=1 are presented at t+1. rd_valid is a single-cycle pulse per request; back-to-back reads are allowed, one per cycle.
  - The value returned is the stored value before any update on edge t.
  - Address map:
    - 0..NBINS-1: ipi bins
    - NBINS..NBINS+NCHAN-1: chcnt[0..NCHAN-1]
    - NBINS+NCHAN: ovf
    - NBINS+NCHAN+1: total
    - any other address: returns 0
  - Reads during a sweep are legal and return the current, partially cleared contents.
- rd_data holds its last value when rd_valid=0.

Test Plan:
- Reset, then pulse buffer=8'h01 at cycles 10, 13, 14; mask=8'hFF, enable=1 -> ipi[2]=1, ipi[0]=1, chcnt[0]=3, total=3, ovf=0; all other addresses read 0.
- BIN_SHIFT=2, hits 9 cycles apart, 5 hits -> ipi[2]=4 (cyc=8); first hit records no interval.
- Hits 70 cycles apart with NBINS=64 -> ovf increments per interval, no ipi bin changes; gap of 70000 cycles -> cyc saturates at 65535, still counted in ovf.
- chan_mask=8'h02, buffer alternates 8'h01/8'h02 every 3 cycles -> chcnt[0], chcnt[1] both count; IPI records only the 6-cycle spacing of ch1 (bin 5).
- Clear pulse mid-stream -> clear_busy high exactly 64 cycles; hits during the sweep are ignored; afterwards every address reads 0; the first post-sweep hit is not binned.
- CNT_W=4, 20 hits on ch3 -> chcnt[3]=15 (saturated). Assert reset concurrently with rd_en and clear -> next cycle rd_valid=0, clear_busy=0, all reads 0.
